// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC sample UART packetizer.
package adc_pkt_pkg;

    // Packetizer FSM states, in on-the-wire order of the packet fields.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_SEQ,
        ST_FLAGS,
        ST_PAY_REQ,
        ST_PAY_CAP,
        ST_PAY_TX,
        ST_CHK,
        ST_DONE
    } pkt_state_t;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

    // Bit of the FLAGS byte that reports a FIFO-full event since the last packet.
    localparam int FLAG_FULL = 0;

    // SYNC0, SYNC1, SEQ, FLAGS.
    localparam int HDR_LEN = 4;

    // Build the FLAGS byte; all bits other than FLAG_FULL are reserved zero.
    function automatic logic [7:0] make_flags(input logic full);
        logic [7:0] f;
        f = 8'h00;
        f[FLAG_FULL] = full;
        return f;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. ready is also high in the last cycle of the stop bit
// so a load there starts the next frame with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       rd_clk,
    input  logic       rd_rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_STOP  = 4'd9;

    logic          active_q, active_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic          last_tick;

    assign last_tick = active_q && (baud_q == BAUD_LAST) && (bit_q == BIT_STOP);
    assign ready     = !active_q || last_tick;
    // Idle line is high; reset clears active_q so tx rises without a clock.
    assign tx        = active_q ? shift_q[0] : 1'b1;

    // Next-state: accept a new frame when ready, otherwise advance baud/bit counters.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (load && ready) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = 4'd0;
            shift_d  = {1'b1, data, 1'b0};
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == BIT_STOP) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous reset to the idle line.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= 10'h3FF;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: rtl/adc_uart_packetizer.sv
// Pulls bytes from the width-conversion FIFO read port and frames them as
// SYNC0 SYNC1 SEQ FLAGS payload CHK packets over an 8N1 UART line.
module adc_uart_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         PAYLOAD_LEN  = 64,
    parameter logic [7:0] SYNC0        = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1        = SYNC1_DEFAULT
) (
    input  logic        rd_clk,
    input  logic        rd_rst_n,
    input  logic        enable,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    input  logic        fifo_rd_full,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    pkt_state_t  state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        full_q, full_d;
    logic [15:0] pkt_count_q, pkt_count_d;

    logic        uart_ready;
    logic        uart_load;
    logic [7:0]  uart_data;
    logic [7:0]  flags;

    assign flags     = make_flags(full_q);
    assign busy      = (state_q != ST_IDLE);
    assign pkt_count = pkt_count_q;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .rd_clk  (rd_clk),
        .rd_rst_n(rd_rst_n),
        .load    (uart_load),
        .data    (uart_data),
        .ready   (uart_ready),
        .tx      (tx)
    );

    // FSM state register.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // FSM next state: header/CHK fields advance on each accepted UART load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable && !fifo_empty) state_d = ST_SYNC0;
            ST_SYNC0:   if (uart_ready) state_d = ST_SYNC1;
            ST_SYNC1:   if (uart_ready) state_d = ST_SEQ;
            ST_SEQ:     if (uart_ready) state_d = ST_FLAGS;
            ST_FLAGS:   if (uart_ready) state_d = ST_PAY_REQ;
            ST_PAY_REQ: if (uart_ready && !fifo_empty) state_d = ST_PAY_CAP;
            ST_PAY_CAP: state_d = ST_PAY_TX;
            ST_PAY_TX:  if (uart_ready) state_d = (cnt_q == LAST_IDX) ? ST_CHK : ST_PAY_REQ;
            ST_CHK:     if (uart_ready) state_d = ST_DONE;
            ST_DONE:    if (uart_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: UART load/data mux and the single-cycle FIFO read strobe.
    always_comb begin
        uart_load  = 1'b0;
        uart_data  = 8'h00;
        fifo_rd_en = 1'b0;
        case (state_q)
            ST_SYNC0:   begin uart_load = uart_ready; uart_data = SYNC0;  end
            ST_SYNC1:   begin uart_load = uart_ready; uart_data = SYNC1;  end
            ST_SEQ:     begin uart_load = uart_ready; uart_data = seq_q;  end
            ST_FLAGS:   begin uart_load = uart_ready; uart_data = flags;  end
            ST_PAY_REQ: fifo_rd_en = uart_ready && !fifo_empty;
            ST_PAY_TX:  begin uart_load = uart_ready; uart_data = data_q; end
            ST_CHK:     begin uart_load = uart_ready; uart_data = chk_q;  end
            default:    ;
        endcase
    end

    // Datapath next state: checksum, payload counter, sticky full flag, counters.
    always_comb begin
        seq_d       = seq_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        pkt_count_d = pkt_count_q;
        full_d      = full_q;
        if (state_q == ST_FLAGS && uart_ready) full_d = 1'b0;
        // Applied after the clear so a coinciding full event is not lost.
        if (fifo_rd_full) full_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                chk_d = 8'h00;
                cnt_d = 8'h00;
            end
            ST_SEQ:    if (uart_ready) chk_d = chk_q ^ seq_q;
            ST_FLAGS:  if (uart_ready) chk_d = chk_q ^ flags;
            ST_PAY_CAP: begin
                data_d = fifo_dout;
                chk_d  = chk_q ^ fifo_dout;
            end
            ST_PAY_TX: if (uart_ready) cnt_d = cnt_q + 8'd1;
            ST_DONE: if (uart_ready) begin
                seq_d       = seq_q + 8'd1;
                pkt_count_d = pkt_count_q + 16'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            seq_q       <= 8'h00;
            chk_q       <= 8'h00;
            cnt_q       <= 8'h00;
            data_q      <= 8'h00;
            full_q      <= 1'b0;
            pkt_count_q <= 16'h0000;
        end else begin
            seq_q       <= seq_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            full_q      <= full_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_adc_uart_packetizer.sv
// Scoreboard bench for adc_uart_packetizer: stimulus pushes expected wire bytes,
// a UART decoder on tx pops and compares them.
module tb_adc_uart_packetizer;

    localparam int CPB   = 4;
    localparam int PL    = 4;
    localparam int FRAME = 10 * CPB;

    typedef struct {
        logic [7:0] b;
        bit         contig;
    } exp_t;

    logic        rd_clk       = 1'b0;
    logic        rd_rst_n     = 1'b0;
    logic        enable       = 1'b0;
    logic        fifo_rd_full = 1'b0;
    logic [7:0]  fifo_dout    = 8'h00;
    logic        fifo_empty   = 1'b1;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int base;

    logic [7:0] fq[$];
    exp_t       exp_q[$];

    int         mon_start;
    int         mon_last = -1000;
    bit         mon_ab;
    logic [7:0] mon_d;
    exp_t       mon_e;

    adc_uart_packetizer #(
        .CLKS_PER_BIT(CPB),
        .PAYLOAD_LEN (PL)
    ) dut (
        .rd_clk      (rd_clk),
        .rd_rst_n    (rd_rst_n),
        .enable      (enable),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_rd_full(fifo_rd_full),
        .fifo_rd_en  (fifo_rd_en),
        .tx          (tx),
        .busy        (busy),
        .pkt_count   (pkt_count)
    );

    always #5 rd_clk = ~rd_clk;
    always @(posedge rd_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: standard-mode read, data valid the cycle after rd_en.
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            check("rd_en_not_empty", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) begin
                fifo_dout <= fq.pop_front();
                rd_cnt    <= rd_cnt + 1;
            end
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic push_fifo(input logic [7:0] b);
        fq.push_back(b);
    endtask

    task automatic exp_byte(input logic [7:0] b, input bit contig);
        exp_t e;
        e.b      = b;
        e.contig = contig;
        exp_q.push_back(e);
    endtask

    // Expected packet with a hand-computed checksum.
    task automatic exp_pkt(input logic [7:0] seq, input logic [7:0] flags,
                           input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3,
                           input logic [7:0] chk);
        exp_byte(8'hA5, 1'b0);
        exp_byte(8'h5A, 1'b1);
        exp_byte(seq,   1'b1);
        exp_byte(flags, 1'b1);
        exp_byte(p0, 1'b0);
        exp_byte(p1, 1'b0);
        exp_byte(p2, 1'b0);
        exp_byte(p3, 1'b0);
        exp_byte(chk, 1'b0);
    endtask

    task automatic wait_pkts(input logic [15:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge rd_clk);
            if (pkt_count == target) break;
        end
    endtask

    task automatic wait_reads(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge rd_clk);
            if (rd_cnt - base >= n) break;
        end
    endtask

    task automatic do_reset();
        enable   = 1'b0;
        rd_rst_n = 1'b0;
        fq.delete();
        repeat (3) @(negedge rd_clk);
        rd_rst_n = 1'b1;
        repeat (2) @(negedge rd_clk);
    endtask

    task automatic mon_wait(input int n);
        for (int i = 0; i < n && !mon_ab; i++) begin
            @(negedge rd_clk);
            if (rd_rst_n !== 1'b1) mon_ab = 1'b1;
        end
    endtask

    // UART decoder: samples bit centres on the falling clock edge.
    initial begin : monitor
        forever begin
            @(negedge rd_clk);
            if (rd_rst_n === 1'b1 && tx === 1'b0) begin
                mon_start = cyc;
                mon_ab    = 1'b0;
                mon_wait(CPB / 2);
                if (!mon_ab) check("start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB);
                    mon_d[i] = tx;
                end
                mon_wait(CPB);
                if (!mon_ab) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h, want none (cycle %0d)", mon_d, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("tx_byte", 32'(mon_d), 32'(mon_e.b));
                        if (mon_e.contig) check("frame_spacing", 32'(mon_start - mon_last), 32'(FRAME));
                    end
                    mon_last = mon_start;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // 1: reset state, held idle with enable low.
        repeat (3) @(negedge rd_clk);
        check("in_reset", {tx, fifo_rd_en, busy, pkt_count}, {1'b1, 1'b0, 1'b0, 16'h0000});
        rd_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge rd_clk);
            check("reset_idle", {tx, fifo_rd_en, busy, pkt_count}, {1'b1, 1'b0, 1'b0, 16'h0000});
        end

        // 2: one full packet, CHK = 00^00^11^22^33^44 = 44.
        push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33); push_fifo(8'h44);
        exp_pkt(8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        base   = rd_cnt;
        enable = 1'b1;
        wait_pkts(16'd1, 800);
        check("s2_pkt_count", 32'(pkt_count), 32'd1);
        check("s2_busy", 32'(busy), 32'd0);
        check("s2_tx_idle", 32'(tx), 32'd1);
        check("s2_rd_pulses", 32'(rd_cnt - base), 32'd4);
        check("s2_drained", 32'(exp_q.size()), 32'd0);

        // 3: FIFO underflow mid-payload, line idles until data arrives.
        do_reset();
        push_fifo(8'h11); push_fifo(8'h22);
        exp_pkt(8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        base   = rd_cnt;
        enable = 1'b1;
        wait_reads(2, 800);
        check("s3_reads_before_stall", 32'(rd_cnt - base), 32'd2);
        repeat (60) @(negedge rd_clk);
        for (int i = 0; i < 140; i++) begin
            @(negedge rd_clk);
            check("s3_stall_idle", {tx, fifo_rd_en, busy}, 3'b101);
        end
        push_fifo(8'h33); push_fifo(8'h44);
        wait_pkts(16'd1, 800);
        check("s3_pkt_count", 32'(pkt_count), 32'd1);
        check("s3_busy", 32'(busy), 32'd0);
        check("s3_rd_pulses", 32'(rd_cnt - base), 32'd4);
        check("s3_drained", 32'(exp_q.size()), 32'd0);

        // 4: full pulse during packet 0 payload shows up in packet 1 FLAGS only.
        do_reset();
        push_fifo(8'h01); push_fifo(8'h02); push_fifo(8'h03); push_fifo(8'h04);
        push_fifo(8'h10); push_fifo(8'h20); push_fifo(8'h30); push_fifo(8'h40);
        push_fifo(8'hAA); push_fifo(8'hBB); push_fifo(8'hCC); push_fifo(8'hDD);
        exp_pkt(8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        exp_pkt(8'h01, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40);
        exp_pkt(8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02);
        base   = rd_cnt;
        enable = 1'b1;
        wait_reads(1, 800);
        fifo_rd_full = 1'b1;
        @(negedge rd_clk);
        fifo_rd_full = 1'b0;
        wait_pkts(16'd3, 2400);
        check("s4_pkt_count", 32'(pkt_count), 32'd3);
        check("s4_rd_pulses", 32'(rd_cnt - base), 32'd12);
        check("s4_drained", 32'(exp_q.size()), 32'd0);

        // 5: enable dropped mid-payload, packet completes, no restart.
        do_reset();
        for (int i = 0; i < 8; i++) push_fifo(8'(8'h21 + i));
        exp_pkt(8'h00, 8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h04);
        base   = rd_cnt;
        enable = 1'b1;
        wait_reads(1, 800);
        enable = 1'b0;
        wait_pkts(16'd1, 800);
        check("s5_pkt_count", 32'(pkt_count), 32'd1);
        repeat (150) @(negedge rd_clk);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_pkt_hold", 32'(pkt_count), 32'd1);
        check("s5_fifo_left", 32'(fq.size()), 32'd4);
        check("s5_rd_pulses", 32'(rd_cnt - base), 32'd4);
        check("s5_drained", 32'(exp_q.size()), 32'd0);

        // 6: reset during data bit 1 (a zero bit of A5) of packet 1 SYNC0.
        do_reset();
        push_fifo(8'h31); push_fifo(8'h32); push_fifo(8'h33); push_fifo(8'h34);
        push_fifo(8'h41); push_fifo(8'h42); push_fifo(8'h43); push_fifo(8'h44);
        exp_pkt(8'h00, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h04);
        enable = 1'b1;
        wait_pkts(16'd1, 800);
        check("s6_pkt0_done", 32'(pkt_count), 32'd1);
        check("s6_pkt0_drained", 32'(exp_q.size()), 32'd0);
        repeat (11) @(negedge rd_clk);
        check("s6_tx_low_before_reset", 32'(tx), 32'd0);
        check("s6_busy_before_reset", 32'(busy), 32'd1);
        rd_rst_n = 1'b0;
        #1;
        check("s6_async_tx", 32'(tx), 32'd1);
        check("s6_async_pkt_count", 32'(pkt_count), 32'd0);
        check("s6_async_busy", 32'(busy), 32'd0);
        exp_pkt(8'h00, 8'h00, 8'h41, 8'h42, 8'h43, 8'h44, 8'h04);
        repeat (3) @(negedge rd_clk);
        base     = rd_cnt;
        rd_rst_n = 1'b1;
        wait_pkts(16'd1, 800);
        check("s6_pkt_count", 32'(pkt_count), 32'd1);
        check("s6_rd_pulses", 32'(rd_cnt - base), 32'd4);
        check("s6_drained", 32'(exp_q.size()), 32'd0);

        enable = 1'b0;
        repeat (20) @(negedge rd_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
